// File: rtl/ahb_pkg.sv
// AHB-Lite protocol constants and types shared by the AHB-Lite master.
//   htrans_t      : HTRANS encodings
//   BYTE/HALF/WORD: HSIZE encodings supported by the master
//   HRESP_*       : HRESP encodings
//   HBURST_SINGLE : the only burst type the master issues
//   ahbm_state_t  : master error-handling FSM state (NORMAL, ERR_CANCEL)
//   addr_misaligned(): alignment test of a byte address against an HSIZE value
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef logic [0:0] ahbm_state_t;
  localparam ahbm_state_t NORMAL     = 1'b0;
  localparam ahbm_state_t ERR_CANCEL = 1'b1;

  function automatic logic addr_misaligned(input logic [31:0] addr, input logic [2:0] size);
    case (size)
      HALF:    return addr[0];
      WORD:    return |addr[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite initiator. Converts a valid/ready request stream into
// pipelined SINGLE transfers and returns in-order responses.
//
// Ports:
//   HCLK, HRESET            : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready     : request handshake (req_ready is combinational)
//   req_write, req_addr,
//   req_size, req_wdata     : request payload
//   rsp_valid, rsp_rdata,
//   rsp_err                 : one-cycle response pulse, in request order
//   HADDR..HWDATA           : AHB-Lite master outputs
//   HRDATA, HREADY, HRESP   : AHB-Lite slave responses
//
// Optional build macro AHBM_ALIGN_CHECK_EN: misaligned requests are not put on
// the bus and complete with rsp_err=1, rsp_rdata=0, keeping response order.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // Address slot: the request currently presented in (or waiting for) an address phase.
  logic        a_valid_q;
  logic        a_write_q;
  logic [31:0] a_addr_q;
  logic [2:0]  a_size_q;
  logic [31:0] a_wdata_q;

  // Data slot: the transfer currently in its data phase.
  logic        d_valid_q;
  logic        d_write_q;
  logic [31:0] hwdata_q;

  ahbm_state_t state_q, state_d;

  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic a_bad;
  logic d_bad;
  logic is_normal;
  logic d_live;
  logic accept;
  logic a_move;
  logic complete;

`ifdef AHBM_ALIGN_CHECK_EN
  logic a_bad_q;
  logic d_bad_q;

  assign a_bad = a_bad_q;
  assign d_bad = d_bad_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_bad_q <= 1'b0;
      d_bad_q <= 1'b0;
    end else begin
      if (accept) begin
        a_bad_q <= addr_misaligned(req_addr, req_size);
      end
      if (a_move) begin
        d_bad_q <= a_bad_q;
      end
    end
  end
`else
  assign a_bad = 1'b0;
  assign d_bad = 1'b0;
`endif

  assign is_normal = (state_q == NORMAL);
  // A bad entry in D never reached the bus, so HRESP does not belong to it.
  assign d_live    = d_valid_q && !d_bad;

  assign req_ready = !a_valid_q ||
                     (HREADY && is_normal && !(d_live && (HRESP == HRESP_ERROR)));
  assign accept    = req_valid && req_ready;
  // A leaves the address slot on a ready edge in NORMAL: either its NONSEQ was
  // taken, or it is a bad entry that was held IDLE.
  assign a_move    = HREADY && a_valid_q && is_normal;
  // Bad entries complete on the edge after entering D, whatever HREADY is.
  assign complete  = d_valid_q && (HREADY || d_bad);

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if (d_live && (HRESP == HRESP_ERROR) && !HREADY) begin
          state_d = ERR_CANCEL;
        end
      end
      ERR_CANCEL: begin
        if (HREADY) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_addr_q  <= '0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
    end else if (accept) begin
      a_valid_q <= 1'b1;
      a_write_q <= req_write;
      a_addr_q  <= req_addr;
      a_size_q  <= req_size;
      a_wdata_q <= req_wdata;
    end else if (a_move) begin
      a_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      hwdata_q  <= '0;
    end else if (a_move) begin
      d_valid_q <= 1'b1;
      d_write_q <= a_write_q;
      if (!a_bad) begin
        hwdata_q <= a_wdata_q;
      end
    end else if (complete) begin
      d_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete;
      rsp_rdata_q <= (complete && !d_write_q && !d_bad) ? HRDATA : 32'h0;
      rsp_err_q   <= complete && (d_bad || (HRESP == HRESP_ERROR));
    end
  end

  assign HTRANS    = (a_valid_q && is_normal && !a_bad) ? NONSEQ : IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = hwdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Testbench for ahb_lite_master: a behavioural AHB-Lite slave with its own
// memory, a transaction-level reference model (expected response queue plus a
// shadow memory), directed protocol scenarios and a randomized phase.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // mem[0] belongs to the slave, mem[1] to the reference model.
  logic [7:0] mem [0:1][0:255];

  function automatic void write_mem(input int which, input logic [31:0] addr,
                                    input logic [2:0] size, input logic [31:0] wdata);
    int n;
    logic [31:0] base;
    n    = 1 << size;
    base = addr & ~(32'(n) - 32'd1);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      mem[which][a[7:0]] = wdata[8*a[1:0] +: 8];
    end
  endfunction

  function automatic logic [31:0] read_word(input int which, input logic [31:0] addr);
    logic [7:0] b;
    b = {addr[7:2], 2'b00};
    return {mem[which][b+8'd3], mem[which][b+8'd2], mem[which][b+8'd1], mem[which][b]};
  endfunction

  function automatic logic is_err_addr(input logic [31:0] addr);
    return (addr[7:2] == 6'h10) || (addr[7:2] == 6'h20);
  endfunction

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];

  // ---------------- behavioural slave ----------------
  int          fixed_waits = 0;
  logic        rand_waits  = 1'b0;
  logic [1:0]  s_trans;
  logic [31:0] s_addr, s_wdata;
  logic        s_write, s_ready;
  logic [2:0]  s_size;
  logic        dp_valid = 1'b0, dp_write, dp_err, dp_err1;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  int          dp_waits;

  initial begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      s_trans = HTRANS;
      s_addr  = HADDR;
      s_write = HWRITE;
      s_size  = HSIZE;
      s_wdata = HWDATA;
      s_ready = HREADY;
      @(posedge HCLK);
      #1;
      if (HRESET) begin
        dp_valid = 1'b0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        HRDATA   = 32'h0;
      end else begin
        if (dp_valid && s_ready) begin
          if (dp_write && !dp_err) write_mem(0, dp_addr, dp_size, s_wdata);
          dp_valid = 1'b0;
        end
        if (s_ready && s_trans == NONSEQ) begin
          dp_valid = 1'b1;
          dp_addr  = s_addr;
          dp_write = s_write;
          dp_size  = s_size;
          dp_err   = is_err_addr(s_addr);
          dp_err1  = 1'b0;
          dp_waits = rand_waits ? int'($urandom_range(0, 2)) : fixed_waits;
        end
        if (!dp_valid) begin
          HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        end else if (dp_waits > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
          dp_waits--;
        end else if (dp_err && !dp_err1) begin
          HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'h0;
          dp_err1 = 1'b1;
        end else begin
          HREADY = 1'b1; HRESP = dp_err;
          HRDATA = (!dp_write && !dp_err) ? read_word(0, dp_addr) : 32'h0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  int cycle     = 0;
  int rsp_count = 0;
  int ns_cycle [logic [31:0]];

  initial begin
    forever begin
      @(negedge HCLK);
      cycle++;
      if (!HRESET) begin
        if (HTRANS == NONSEQ && HREADY) ns_cycle[HADDR] = cycle;
        if (rsp_valid) begin
          rsp_count++;
          if (q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'h0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("rsp_rdata@%08h", e.addr), rsp_rdata, e.rdata);
            check($sformatf("rsp_err@%08h", e.addr), 32'(rsp_err), 32'(e.err));
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
    int   n;
    logic misal;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    @(negedge HCLK);
    while (!req_ready) begin
      n++;
      if (n > 200) begin
        check("req_ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b0;
        return;
      end
      @(negedge HCLK);
    end
    misal = 1'b0;
`ifdef AHBM_ALIGN_CHECK_EN
    misal = (size == HALF && addr[0]) || (size == WORD && addr[1:0] != 2'b00);
`endif
    e.addr  = addr;
    e.err   = misal || is_err_addr(addr);
    e.rdata = (wr || e.err) ? 32'h0 : read_word(1, addr);
    if (wr && !e.err) write_mem(1, addr, size, wdata);
    q.push_back(e);
    @(posedge HCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'h0);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) mem[w][i] = 8'h00;
    HRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_size  = 3'b000;
    req_wdata = 32'h0;
    #2;
    check("reset_htrans", 32'(HTRANS), 32'(IDLE));
    check("reset_haddr", HADDR, 32'h0);
    check("reset_hwrite", 32'(HWRITE), 32'h0);
    check("reset_hsize", 32'(HSIZE), 32'h0);
    check("reset_hwdata", HWDATA, 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    // 1: single read, zero wait
    write_mem(0, 32'h10, WORD, 32'hDEADBEEF);
    write_mem(1, 32'h10, WORD, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, WORD, 32'h0);
    @(negedge HCLK);
    check("t1_nonseq", 32'(HTRANS), 32'(NONSEQ));
    check("t1_haddr", HADDR, 32'h10);
    check("t1_hsize", 32'(HSIZE), 32'(WORD));
    check("t1_hwrite", 32'(HWRITE), 32'h0);
    @(negedge HCLK);
    check("t1_rsp_early", 32'(rsp_valid), 32'h0);
    @(negedge HCLK);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    @(posedge HCLK);
    #1;

    // 2: write then read back-to-back
    base = rsp_count;
    do_req(1'b1, 32'h20, WORD, 32'h12345678);
    do_req(1'b0, 32'h24, WORD, 32'hCAFE0024);
    @(negedge HCLK);
    check("t2_read_nonseq", 32'(HTRANS), 32'(NONSEQ));
    check("t2_read_haddr", HADDR, 32'h24);
    check("t2_hwdata", HWDATA, 32'h12345678);
    drain();
    check("t2_consecutive", 32'(ns_cycle[32'h24] - ns_cycle[32'h20]), 32'h1);
    check("t2_rsp_count", 32'(rsp_count - base), 32'h2);

    // 3: three wait states with the next request waiting in A
    fixed_waits = 3;
    do_req(1'b0, 32'h30, WORD, 32'hA5A50030);
    do_req(1'b0, 32'h34, WORD, 32'hA5A50034);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("t3_haddr", HADDR, 32'h34);
      check("t3_htrans", 32'(HTRANS), 32'(NONSEQ));
      check("t3_hwdata", HWDATA, 32'hA5A50030);
      check("t3_req_ready", 32'(req_ready), 32'h0);
      check("t3_rsp_idle", 32'(rsp_valid), 32'h0);
    end
    @(negedge HCLK);
    check("t3_rsp_not_yet", 32'(rsp_valid), 32'h0);
    @(negedge HCLK);
    check("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    fixed_waits = 0;
    @(posedge HCLK);
    #1;
    drain();

    // 4: two-cycle ERROR on write 0x40, read 0x44 pending
    do_req(1'b1, 32'h40, WORD, 32'h0BAD0040);
    do_req(1'b0, 32'h44, WORD, 32'h0);
    @(negedge HCLK);
    check("t4_err1_htrans", 32'(HTRANS), 32'(NONSEQ));
    check("t4_err1_rsp", 32'(rsp_valid), 32'h0);
    @(negedge HCLK);
    check("t4_err2_idle", 32'(HTRANS), 32'(IDLE));
    check("t4_err2_haddr", HADDR, 32'h44);
    @(negedge HCLK);
    check("t4_reissue", 32'(HTRANS), 32'(NONSEQ));
    check("t4_reissue_haddr", HADDR, 32'h44);
    check("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t4_rsp_err", 32'(rsp_err), 32'h1);
    @(posedge HCLK);
    #1;
    drain();

    // 5: reset while a read is stalled
    fixed_waits = 5;
    do_req(1'b0, 32'h50, WORD, 32'h77770050);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check("t5_htrans", 32'(HTRANS), 32'(IDLE));
    check("t5_haddr", HADDR, 32'h0);
    check("t5_hwrite", 32'(HWRITE), 32'h0);
    check("t5_hsize", 32'(HSIZE), 32'h0);
    check("t5_hwdata", HWDATA, 32'h0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_req_ready", 32'(req_ready), 32'h1);
    q.delete();
    fixed_waits = 0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    base = rsp_count;
    repeat (10) @(negedge HCLK);
    check("t5_no_rsp_after_reset", 32'(rsp_count - base), 32'h0);
    @(posedge HCLK);
    #1;

`ifdef AHBM_ALIGN_CHECK_EN
    // 6: misaligned halfword read between two good reads
    do_req(1'b0, 32'h08, WORD, 32'h0);
    do_req(1'b0, 32'h03, HALF, 32'h0);
    do_req(1'b0, 32'h0C, WORD, 32'h0);
    drain();
    check("t6_no_nonseq", 32'(ns_cycle.exists(32'h03)), 32'h0);
    check("t6_next_issued", 32'(ns_cycle.exists(32'h0C)), 32'h1);
`endif

    // Randomized phase: aligned requests, random waits and gaps.
    rand_waits = 1'b1;
    repeat (300) begin
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] ad;
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
      do_req(wr, ad, sz, $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator; the bus-side counterpart of the SRAM AHB slave.
- Turns a simple valid/ready request stream into pipelined SINGLE transfers, address phase overlapped with the previous data phase.
- Returns in-order responses (read data plus error flag).
- Sits between on-chip requesters (DMA, debug bridge, test driver) and the AHB-Lite fabric/decoder.

Parameters:
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data).

Ports:
- HCLK input 1: clock; all logic is on the rising edge.
- HRESET input 1: asynchronous, active-high reset.
- req_valid input 1: request present.
- req_ready output 1: request accepted at this edge when req_valid is also high.
- req_write input 1: 1 = write, 0 = read.
- req_addr input 32: byte address.
- req_size input 3: HSIZE encoding, 0..2 only.
- req_wdata input 32: write data, lane-aligned per AHB.
- rsp_valid output 1: one-cycle pulse, one per accepted request, in order.
- rsp_rdata output 32: read data; 0 for writes.
- rsp_err output 1: transfer ended in ERROR.
- HADDR output 32, HTRANS output 2, HWRITE output 1, HSIZE output 3, HBURST output 3 (tied 3'b000), HPROT output 4, HWDATA output 32: AHB-Lite master outputs.
- HRDATA input 32, HREADY input 1, HRESP input 1: AHB-Lite inputs.

Behaviour:
- Clock is HCLK; reset HRESET is asynchronous, active-high.
- Reset values:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Both slots empty; FSM=NORMAL.
- Reset mid-transfer: both slots are dropped and no response is produced.
- Slots:
  - Address slot (A) holds the flopped request driving HADDR/HWRITE/HSIZE. HTRANS=NONSEQ when A is valid and FSM=NORMAL, else IDLE.
  - Data slot (D) holds the in-flight transfer; HWDATA is flopped from A on the A->D move and held through wait states.
- req_ready = !A.valid || (HREADY && FSM==NORMAL && !(D.valid && HRESP)). It is combinational; there is no combinational path from req_* to bus outputs.
- Accept: request loads A at the edge. HTRANS=NONSEQ appears the following cycle, so latency from acceptance to address phase is 1 cycle.
- Advance: at an edge with HREADY=1, A moves to D when HTRANS was NONSEQ; otherwise D empties.
- Completion: at an edge with D.valid && HREADY=1, pulse rsp_valid the next cycle.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - rsp_err = HRESP.
- Back-to-back: one transfer every cycle is sustained with zero wait states. A write followed by a read needs no bubble.
- FSM states:
  - NORMAL -> ERR_CANCEL on an edge with D.valid && HRESP=1 && HREADY=0 (first error cycle).
  - ERR_CANCEL forces HTRANS=IDLE and keeps A's contents, cancelling the pending address phase.
  - ERR_CANCEL -> NORMAL on an edge with HREADY=1. That edge completes the erroring transfer (rsp_err=1); A does not advance.
  - The cancelled transfer re-issues as NONSEQ in the first NORMAL cycle.
- Wait states (HREADY=0, HRESP=0): all bus outputs hold stable; no slot moves.
- HRESP=1 with HREADY=1 while FSM=NORMAL is a protocol violation by the slave. It is treated as completion with rsp_err=1.
- req_size > 2 is unsupported: the request is issued as given and its behaviour is undefined.

Optional Feature:
- Macro: AHBM_ALIGN_CHECK_EN.
- When defined:
  - A request whose address is misaligned for req_size is accepted but marked bad.
  - A bad entry in A drives HTRANS=IDLE and moves to D at the next HREADY=1 edge.
  - In D it completes on the following edge regardless of HREADY, with rsp_err=1, rsp_rdata=0. HWDATA is unchanged.
  - Response ordering is preserved.
- When undefined: addresses are issued unchecked; alignment is the requester's duty.

Decomposition:
- Package ahb_pkg:
  - htrans_t (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - hsize constants BYTE/HALF/WORD.
  - HRESP_OKAY/HRESP_ERROR.
  - HBURST_SINGLE.
  - ahbm_state_t {NORMAL, ERR_CANCEL}.
- No sub-module; a single module is natural.

Test Plan:
1. Read 0x0000_0010 size 2, zero wait, HRDATA=0xDEADBEEF:
   - NONSEQ 1 cycle after accept.
   - rsp_valid pulse with rdata=0xDEADBEEF, err=0, 2 cycles after the address phase.
2. Write 0x20 data 0x12345678 then read 0x24, back-to-back:
   - NONSEQ on consecutive cycles.
   - HWDATA=0x12345678 during the read's address phase.
   - Two in-order responses.
3. Read with HREADY low for 3 cycles while the next request is in A:
   - HADDR/HTRANS/HWDATA stable.
   - req_ready=0 throughout.
   - Response pulses after the 3rd wait cycle.
4. Two-cycle ERROR on write 0x40 with read 0x44 pending:
   - HTRANS=IDLE in the second error cycle.
   - rsp_err=1 for 0x40.
   - 0x44 re-issued NONSEQ the next cycle and completes err=0.
5. Assert HRESET while a read is stalled:
   - Outputs return to reset values immediately.
   - No rsp_valid after deassert.
6. With AHBM_ALIGN_CHECK_EN, halfword read at 0x03:
   - No NONSEQ driven.
   - rsp_valid with rsp_err=1, rsp_rdata=0, ordered after the preceding transfers.
